// File: rtl/cache_write_buffer.sv
// Write buffer between the cache controller and the way arrays: queues CPU write-back beats and
// critical-word-first line fills, then drains one beat per cycle to the target way.
module cache_write_buffer #(
   parameter int unsigned NUM_WAYS       = 4,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter int unsigned FIFO_DEPTH     = 4,
   localparam int unsigned BE_W          = DATA_WIDTH / 8,
   localparam int unsigned WW            = $clog2(WORDS_PER_LINE),
   localparam int unsigned CW            = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  reqValid,
   output logic                  reqReady,
   input  logic [NUM_WAYS-1:0]   reqWay,
   input  logic [WW-1:0]         reqWord,
   input  logic [DATA_WIDTH-1:0] reqData,
   input  logic [BE_W-1:0]       reqByteEn,
   input  logic                  reqFill,
   input  logic [NUM_WAYS-1:0]   wayBusy,
   output logic [NUM_WAYS-1:0]   wayWEn,
   output logic [WW-1:0]         wayWord,
   output logic [DATA_WIDTH-1:0] wayData,
   output logic [BE_W-1:0]       wayByteEn,
   output logic                  errInvalidWay,
   output logic                  burstActive,
   output logic [CW-1:0]         fifoCount,
   output logic                  idle
);

   localparam int unsigned PW = CW - 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e                state_q, state_d;
   logic [NUM_WAYS-1:0]   burst_way_q;
   logic [WW-1:0]         burst_word_q;
   logic [WW-1:0]         beats_left_q;

   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]         count_q;

   logic [NUM_WAYS-1:0]   mem_way  [FIFO_DEPTH];
   logic [WW-1:0]         mem_word [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic [BE_W-1:0]       mem_be   [FIFO_DEPTH];

   logic [NUM_WAYS-1:0]   wen_q;
   logic [WW-1:0]         word_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [BE_W-1:0]       be_q;
   logic                  err_q;

   logic                  accept, one_hot, push, pop, drop, load_burst, step_burst;
   logic [NUM_WAYS-1:0]   push_way, head_way;
   logic [WW-1:0]         push_word;
   logic [BE_W-1:0]       push_be;

   assign reqReady = (count_q < DEPTH_C);
   assign accept   = reqValid && reqReady;
   assign one_hot  = (reqWay != '0) && ((reqWay & (reqWay - NUM_WAYS'(1))) == '0);

   always_comb begin
      state_d    = state_q;
      push       = 1'b0;
      drop       = 1'b0;
      load_burst = 1'b0;
      step_burst = 1'b0;
      push_way   = reqWay;
      push_word  = reqWord;
      push_be    = reqByteEn;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (!one_hot) begin
                  drop = 1'b1;
               end else begin
                  push = 1'b1;
                  if (reqFill) begin
                     push_be    = '1;
                     load_burst = 1'b1;
                     state_d    = StBurst;
                  end
               end
            end
         end
         StBurst: begin
            // Inside a fill the request's way/word/fill fields are don't-care.
            if (accept) begin
               push       = 1'b1;
               step_burst = 1'b1;
               push_way   = burst_way_q;
               push_word  = burst_word_q;
               push_be    = '1;
               if (beats_left_q == WW'(1)) state_d = StIdle;
            end
         end
      endcase
   end

   // Head way is one-hot, so masking with wayBusy selects its busy bit.
   assign head_way = mem_way[rd_ptr_q];
   assign pop      = (count_q != '0) && ((head_way & wayBusy) == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         burst_way_q  <= '0;
         burst_word_q <= '0;
         beats_left_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         wen_q        <= '0;
         word_q       <= '0;
         data_q       <= '0;
         be_q         <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= drop;
         if (load_burst) begin
            burst_way_q  <= reqWay;
            burst_word_q <= reqWord + WW'(1);
            beats_left_q <= WW'(WORDS_PER_LINE - 1);
         end else if (step_burst) begin
            burst_word_q <= burst_word_q + WW'(1);
            beats_left_q <= beats_left_q - WW'(1);
         end
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
         if (pop) begin
            wen_q  <= head_way;
            word_q <= mem_word[rd_ptr_q];
            data_q <= mem_data[rd_ptr_q];
            be_q   <= mem_be[rd_ptr_q];
         end else begin
            wen_q  <= '0;
            word_q <= '0;
            data_q <= '0;
            be_q   <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_way[wr_ptr_q]  <= push_way;
         mem_word[wr_ptr_q] <= push_word;
         mem_data[wr_ptr_q] <= reqData;
         mem_be[wr_ptr_q]   <= push_be;
      end
   end

   assign wayWEn        = wen_q;
   assign wayWord       = word_q;
   assign wayData       = data_q;
   assign wayByteEn     = be_q;
   assign errInvalidWay = err_q;
   assign burstActive   = (state_q == StBurst);
   assign fifoCount     = count_q;
   assign idle          = (count_q == '0) && (state_q == StIdle) && (wen_q == '0);

endmodule
